// File: rtl/level_sensor_filter.sv
// level_sensor_filter: synchronizes, samples and debounces the lower/upper tank level
// sensors, and latches a fault on a persistent upper-wet/lower-dry reading.
module level_sensor_filter #(
    parameter int PRESCALE    = 16,
    parameter int DEBOUNCE    = 4,
    parameter int FAULT_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    input  logic s_raw,
    input  logic fault_clr,
    output logic i_filt,
    output logic s_filt,
    output logic valid,
    output logic change,
    output logic fault
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int FW = $clog2(FAULT_LIMIT + 1);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE);
    localparam logic [FW-1:0] FL_MAX  = FW'(FAULT_LIMIT);

    logic          i_meta_q, s_meta_q, i_sync_q, s_sync_q;
    logic [PW-1:0] ps_q, ps_d;
    logic [DW-1:0] i_cnt_q, i_cnt_d, s_cnt_q, s_cnt_d, warm_q, warm_d;
    logic [FW-1:0] f_cnt_q, f_cnt_d;
    logic          i_int_q, i_int_d, s_int_q, s_int_d;
    logic          i_filt_q, i_filt_d, s_filt_q, s_filt_d;
    logic          valid_q, valid_d, change_q, change_d, fault_q, fault_d;
    logic          tick, implaus;

    // Returns {next filtered value, next counter} for one sample tick.
    function automatic logic [DW:0] deb(input logic sync, input logic filt, input logic [DW-1:0] cnt);
        if (sync == filt) return {filt, DW'(0)};
        if (cnt == DB_LAST) return {~filt, DW'(0)};
        return {filt, cnt + 1'b1};
    endfunction

    always_comb begin
        tick = ps_q == PS_LAST;
        ps_d = tick ? '0 : ps_q + 1'b1;
        {i_int_d, i_cnt_d} = tick ? deb(i_sync_q, i_int_q, i_cnt_q) : {i_int_q, i_cnt_q};
        {s_int_d, s_cnt_d} = tick ? deb(s_sync_q, s_int_q, s_cnt_q) : {s_int_q, s_cnt_q};
        warm_d = (tick && warm_q != DB_MAX) ? warm_q + 1'b1 : warm_q;
        valid_d = valid_q || warm_d == DB_MAX;
        implaus = !i_int_d && s_int_d;
        f_cnt_d = !tick ? f_cnt_q : !implaus ? '0 : (f_cnt_q == FL_MAX) ? f_cnt_q : f_cnt_q + 1'b1;
        // A set in the same cycle as an accepted clear wins.
        fault_d = (f_cnt_d == FL_MAX) || (fault_q && !(fault_clr && f_cnt_q == '0));
        i_filt_d = fault_d ? 1'b0 : i_int_d;
        s_filt_d = fault_d ? 1'b1 : s_int_d;
        change_d = (i_filt_d != i_filt_q) || (s_filt_d != s_filt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_meta_q <= 1'b1;
            s_meta_q <= 1'b1;
            i_sync_q <= 1'b1;
            s_sync_q <= 1'b1;
            ps_q     <= '0;
            i_cnt_q  <= '0;
            s_cnt_q  <= '0;
            warm_q   <= '0;
            f_cnt_q  <= '0;
            i_int_q  <= 1'b1;
            s_int_q  <= 1'b1;
            i_filt_q <= 1'b1;
            s_filt_q <= 1'b1;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            i_meta_q <= i_raw;
            s_meta_q <= s_raw;
            i_sync_q <= i_meta_q;
            s_sync_q <= s_meta_q;
            ps_q     <= ps_d;
            i_cnt_q  <= i_cnt_d;
            s_cnt_q  <= s_cnt_d;
            warm_q   <= warm_d;
            f_cnt_q  <= f_cnt_d;
            i_int_q  <= i_int_d;
            s_int_q  <= s_int_d;
            i_filt_q <= i_filt_d;
            s_filt_q <= s_filt_d;
            valid_q  <= valid_d;
            change_q <= change_d;
            fault_q  <= fault_d;
        end
    end

    assign i_filt = i_filt_q;
    assign s_filt = s_filt_q;
    assign valid  = valid_q;
    assign change = change_q;
    assign fault  = fault_q;
endmodule
